// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit: mode encodings and FSM states.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle of the sequential shift unit.
interface seq_shift_unit_if #(
    parameter int WIDTH   = 12,
    parameter int SHAMT_W = $clog2(WIDTH + 1)
);
    // A transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and payload is stable while valid is high.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/shift_step.sv
// One combinational shift step of k bits (k = 0 passes data through, carry 0).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int SHAMT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] k,
    output logic [WIDTH-1:0]   result,
    output logic               carry
);

    int               kk;
    logic [WIDTH-1:0] tmp;

    assign kk = int'(k);

    // The carry is the bit that ends up last across the boundary, so it is
    // picked by shifting the source bit down to position 0.
    always_comb begin
        result = data;
        carry  = 1'b0;
        tmp    = '0;
        if (kk != 0) begin
            case (mode)
                SH_LSL: begin
                    result = data << kk;
                    tmp    = data >> (WIDTH - kk);
                end
                SH_LSR: begin
                    result = data >> kk;
                    tmp    = data >> (kk - 1);
                end
                SH_ASR: begin
                    result = $unsigned($signed(data) >>> kk);
                    tmp    = data >> (kk - 1);
                end
                default: begin
                    result = (data << kk) | (data >> (WIDTH - kk));
                    tmp    = data >> (WIDTH - kk);
                end
            endcase
            carry = tmp[0];
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROL by a clamped runtime amount, at most STEP bits per clock.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_shift_unit_if.slave  bus,
    output state_t           dbg_state
);

    localparam logic [SHAMT_W-1:0] STEP_K  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] WIDTH_K = SHAMT_W'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [1:0]         mode_q, mode_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic [SHAMT_W-1:0] amt;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    assign amt = (bus.in_shamt > WIDTH_K) ? WIDTH_K : bus.in_shamt;
    assign k   = (rem_q < STEP_K) ? rem_q : STEP_K;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .data   (data_q),
        .mode   (mode_q),
        .k      (k),
        .result (step_data),
        .carry  (step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    mode_d  = bus.in_mode;
                    rem_d   = amt;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    if (amt == '0) begin
                        zero_d  = (bus.in_data == '0);
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d  = step_data;
                rem_d   = rem_q - k;
                carry_d = step_carry;
                if (rem_q == k) begin
                    zero_d  = (step_data == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            mode_q  <= SH_LSL;
            rem_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign bus.out_carry = carry_q;
    assign bus.out_zero  = zero_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: one STEP=1 and one STEP=4 instance driven with random and directed requests.
module tb_seq_shift_unit;
    import shift_pkg::*;

    localparam int W  = 12;
    localparam int EW = 16 + 8 + 1 + W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_shift_unit_if #(.WIDTH(W)) bus0 ();
    seq_shift_unit_if #(.WIDTH(W)) bus1 ();
    state_t st0, st1;

    seq_shift_unit #(.WIDTH(W), .STEP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(st0)
    );
    seq_shift_unit #(.WIDTH(W), .STEP(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(st1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int hold[2] = '{0, 0};
    int last_hs[2] = '{0, 0};
    logic seen[2] = '{1'b0, 1'b0};
    logic [W-1:0] snap_d[2];
    logic snap_c[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: apply the amount one bit at a time following the fill rules.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [3:0] sh,
                                            input logic [1:0] m, input int step, input int acc);
        int amt;
        int lat;
        logic [W-1:0] d;
        logic c;
        amt = (int'(sh) > W) ? W : int'(sh);
        d = a;
        c = 1'b0;
        for (int i = 0; i < amt; i++) begin
            case (m)
                2'b00: begin c = d[W-1]; d = {d[W-2:0], 1'b0}; end
                2'b01: begin c = d[0];   d = {1'b0, d[W-1:1]}; end
                2'b10: begin c = d[0];   d = {d[W-1], d[W-1:1]}; end
                default: begin c = d[W-1]; d = {d[W-2:0], d[W-1]}; end
            endcase
        end
        lat = (amt + step - 1) / step + 1;
        return {16'(acc), 8'(lat), c, d};
    endfunction

    task automatic set_in(input int u, input logic v, input logic [W-1:0] a,
                          input logic [3:0] sh, input logic [1:0] m);
        if (u == 0) begin
            bus0.in_valid = v; bus0.in_data = a; bus0.in_shamt = sh; bus0.in_mode = m;
        end else begin
            bus1.in_valid = v; bus1.in_data = a; bus1.in_shamt = sh; bus1.in_mode = m;
        end
    endtask

    task automatic drive(input int u, input logic [W-1:0] a, input logic [3:0] sh,
                         input logic [1:0] m, output int acc);
        logic rdy;
        logic accepted;
        int tries;
        @(negedge clk);
        set_in(u, 1'b1, a, sh, m);
        accepted = 1'b0;
        tries = 0;
        while (!accepted && tries < 300) begin
            rdy = (u == 0) ? bus0.in_ready : bus1.in_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
            else begin
                tries++;
                @(negedge clk);
            end
        end
        acc = cyc;
        if (accepted) begin
            if (u == 0) exp_q0.push_back(model(a, sh, m, 1, acc));
            else        exp_q1.push_back(model(a, sh, m, 4, acc));
        end else begin
            fail_now("drive_accept");
        end
        set_in(u, 1'b0, W'($urandom), 4'($urandom), 2'($urandom));
    endtask

    task automatic mon(input int u);
        logic ov, ordy, ir, oc, oz;
        logic [W-1:0] od;
        logic [EW-1:0] e;
        int qs;
        int acc;
        if (u == 0) begin
            ov = bus0.out_valid; ordy = bus0.out_ready; ir = bus0.in_ready;
            od = bus0.out_data; oc = bus0.out_carry; oz = bus0.out_zero; qs = exp_q0.size();
        end else begin
            ov = bus1.out_valid; ordy = bus1.out_ready; ir = bus1.in_ready;
            od = bus1.out_data; oc = bus1.out_carry; oz = bus1.out_zero; qs = exp_q1.size();
        end
        if (!rst_n) begin
            seen[u] = 1'b0;
            return;
        end
        if (ov) begin
            if (!seen[u]) begin
                if (qs == 0) begin
                    check($sformatf("unexpected_output_u%0d", u), qs, 1);
                end else begin
                    e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    acc = int'(e[EW-1 -: 16]);
                    check($sformatf("data_u%0d", u), od, e[W-1:0]);
                    check($sformatf("carry_u%0d", u), oc, e[W]);
                    check($sformatf("zero_u%0d", u), oz, (e[W-1:0] == '0));
                    check($sformatf("latency_u%0d", u), cyc - acc + 1, e[W+8:W+1]);
                end
                snap_d[u] = od;
                snap_c[u] = oc;
                seen[u] = 1'b1;
            end else begin
                check($sformatf("hold_data_u%0d", u), od, snap_d[u]);
                check($sformatf("hold_carry_u%0d", u), oc, snap_c[u]);
            end
            check($sformatf("in_ready_in_done_u%0d", u), ir, 1'b0);
            if (ordy) begin
                seen[u] = 1'b0;
                last_hs[u] = cyc + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    always @(posedge clk) begin
        #2;
        bus0.out_ready = (hold[0] != 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        bus1.out_ready = (hold[1] != 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || seen[0] || seen[1]
                || bus0.out_valid || bus1.out_valid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) fail_now("drain");
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready0"}, bus0.in_ready, 1'b1);
        check({tag, "_out_valid0"}, bus0.out_valid, 1'b0);
        check({tag, "_out_data0"}, bus0.out_data, '0);
        check({tag, "_out_carry0"}, bus0.out_carry, 1'b0);
        check({tag, "_out_zero0"}, bus0.out_zero, 1'b0);
        check({tag, "_state0"}, st0, IDLE);
        check({tag, "_in_ready1"}, bus1.in_ready, 1'b1);
        check({tag, "_out_valid1"}, bus1.out_valid, 1'b0);
        check({tag, "_state1"}, st1, IDLE);
    endtask

    initial begin
        #500000;
        fail_now("watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int acc;
        int acc2;
        int u;
        int t;
        set_in(0, 1'b0, '0, '0, '0);
        set_in(1, 1'b0, '0, '0, '0);
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive(0, 12'hABC, 4'd1, SH_LSL, acc);
        drive(0, 12'h800, 4'd3, SH_ASR, acc);
        drive(0, 12'h801, 4'd1, SH_ROL, acc);
        drive(0, 12'h00F, 4'd4, SH_LSR, acc);
        for (int m = 0; m < 4; m++) drive(0, 12'h5A5, 4'd0, 2'(m), acc);
        drive(0, 12'hFFF, 4'd15, SH_LSL, acc);
        drive(0, 12'h9C3, 4'd12, SH_ASR, acc);
        drive(0, 12'h9C3, 4'd12, SH_ROL, acc);
        drive(0, 12'h9C3, 4'd12, SH_LSR, acc);
        drive(1, 12'hFFF, 4'd12, SH_LSL, acc);
        drive(1, 12'hFFF, 4'd5, SH_LSL, acc);
        drive(1, 12'h8A1, 4'd7, SH_ASR, acc);
        drive(1, 12'h8A1, 4'd9, SH_ROL, acc);
        drain();

        // Backpressure: result held 10 cycles while the next request waits.
        hold[0] = 1;
        drive(0, 12'h3C5, 4'd2, SH_ROL, acc);
        fork
            begin
                int tt;
                tt = 0;
                while (!bus0.out_valid && tt < 100) begin
                    @(posedge clk);
                    tt++;
                end
                repeat (10) @(posedge clk);
                hold[0] = 0;
            end
        join_none
        drive(0, 12'h123, 4'd3, SH_LSR, acc2);
        check("accept_after_release", acc2, last_hs[0] + 1);
        drain();

        // Asynchronous reset in the middle of a shift.
        drive(0, 12'hABC, 4'd8, SH_LSL, acc);
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_state", st0, SHIFT);
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        exp_q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 12'h0F1, 4'd5, SH_ROL, acc);
        drain();

        for (int i = 0; i < 80; i++) begin
            u = $urandom_range(0, 1);
            drive(u, W'($urandom), 4'($urandom_range(0, 15)), 2'($urandom), acc);
            t = $urandom_range(0, 2);
            repeat (t) @(posedge clk);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shift unit for the accumulator datapath; successor to the fixed 12-bit, shift-by-one left shifter.
- Supports logical left, logical right, arithmetic right and rotate-left by a runtime amount, shifting at most STEP bits per clock.
- Uses valid/ready handshakes on both sides. Returns the result, a carry (last bit shifted out) and a zero flag to the ALU/accumulator writeback path.

Parameters:
- WIDTH, 12, data width in bits.
- STEP, 1, maximum bits shifted per clock (1..WIDTH).
- SHAMT_W, $clog2(WIDTH+1), width of the shift amount field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_data  in  WIDTH  operand A.
- in_shamt  in  SHAMT_W  shift amount; values above WIDTH clamp to WIDTH.
- in_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  last bit shifted out (ROL: last bit wrapped MSB->LSB); 0 if amount is 0.
- out_zero  out  1  out_data == 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). On reset assertion, immediately: state IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, out_zero=0 (out_zero is registered and cleared to 0, not derived from out_data), internal counters 0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid, latch data, mode and clamped amount into rem; clear carry.
  - rem==0 -> DONE.
  - otherwise -> SHIFT.
- SHIFT: each clock, shift by k = min(STEP, rem); rem -= k; carry = last bit moved out in this step.
  - rem reaching 0 -> DONE.
- DONE: out_data, out_carry and out_zero are stable. Outputs hold while out_ready=0. On out_ready -> IDLE.
- No new request is accepted in the DONE->IDLE cycle; in_ready rises the clock after.
- Latency: request accept edge to out_valid = ceil(amt/STEP)+1 rising edges (amt=0: 1 edge).
- Throughput: one request in flight.
- Per-mode fill:
  - LSL: zero fill at LSB, carry from MSB.
  - LSR: zero fill at MSB, carry from LSB.
  - ASR: replicate MSB, carry from LSB.
  - ROL: MSB wraps to LSB, carry = wrapped bit.
- Amount = WIDTH:
  - LSL/LSR -> 0, carry = A[0] (LSL) or A[WIDTH-1] (LSR).
  - ASR -> all bits = sign, carry = sign.
  - ROL -> A unchanged, carry = A[0].
- in_data, in_shamt and in_mode are ignored when in_ready=0.
- Outputs are unaffected by input changes after acceptance.
- Reset mid-SHIFT or mid-DONE aborts the operation; no partial result is presented.
- in_shamt/in_mode encodings are fully defined (clamping covers overflow amounts); no illegal values.

Decomposition:
- Shared package shift_pkg: mode constants SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROL=2'b11; state encoding IDLE/SHIFT/DONE.
- Sub-module shift_step: combinational unit (data, mode, k in 0..STEP) -> (shifted data, carry bit). Instantiated once; FSM and counter live in seq_shift_unit.

Test Plan:
- WIDTH=12, STEP=1, LSL A=0xABC amt=1 -> out_data=0x578, carry=1, zero=0, out_valid 2 edges after accept ({carry,data}=0x1578 matches legacy left shifter).
- ASR A=0x800 amt=3 -> 0xF00, carry=0. ROL A=0x801 amt=1 -> 0x003, carry=1. LSR A=0x00F amt=4 -> 0x000, carry=1, zero=1.
- amt=0, A=0x5A5, any mode -> 0x5A5, carry=0, out_valid 1 edge after accept. in_shamt=15 LSL A=0xFFF -> clamped to 12 -> 0x000, carry=1.
- STEP=4, LSL A=0xFFF amt=12 -> 0x000, carry=1, out_valid exactly 4 edges after accept. amt=5 -> 0xFE0, carry=1, 3 edges.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data/out_carry stable, in_ready=0, new in_valid ignored; release -> IDLE, next request accepted 1 cycle later.
- Assert rst_n low mid-SHIFT (STEP=1, amt=8, after 3 shifts) -> out_valid=0 and in_ready=1 immediately (asynchronous); after release, a fresh request completes correctly.
